// File: rtl/fn_division.sv
// Iterative restoring divider (RV32M DIV/DIVU/REM/REMU), one quotient bit per clock.
// Optional FN_DIVISION_CERO_RAPIDO_EN: a zero divisor finishes after a single CALC cycle.
module fn_division #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             con_signo,
    output logic             ocupado,
    output logic             listo,
    output logic             div_cero,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] resto,
    output logic [1:0]       estado_dbg
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    // Handshake: an accept happens on a rising edge with inicio=1 while not ocupado;
    // ocupado is high exactly in CALC, listo exactly in DONE, and results are valid while listo.
    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic             sgn_c_q, sgn_c_d;
    logic             sgn_r_q, sgn_r_d;
    logic             cero_q, cero_d;
    logic [WIDTH-1:0] cociente_q, cociente_d;
    logic [WIDTH-1:0] resto_q, resto_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   partial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next, dvd_next;

    always_comb begin
        mag_a = (con_signo && a[WIDTH-1]) ? -a : a;
        mag_b = (con_signo && b[WIDTH-1]) ? -b : b;

        // The dvd register doubles as the quotient: dividend bits leave at the top,
        // quotient bits enter at the bottom.
        partial  = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
        q_bit    = ~partial[WIDTH];
        rem_next = q_bit ? partial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        dvd_next = {dvd_q[WIDTH-2:0], q_bit};

        state_d    = state_q;
        count_d    = count_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        a_orig_d   = a_orig_q;
        sgn_c_d    = sgn_c_q;
        sgn_r_d    = sgn_r_q;
        cero_d     = cero_q;
        cociente_d = cociente_q;
        resto_d    = resto_q;

        case (state_q)
            IDLE, DONE: begin
                if (inicio) begin
                    state_d  = CALC;
                    count_d  = CW'(WIDTH);
                    dvd_d    = mag_a;
                    dvs_d    = mag_b;
                    rem_d    = '0;
                    a_orig_d = a;
                    sgn_c_d  = con_signo & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sgn_r_d  = con_signo & a[WIDTH-1];
                    cero_d   = (b == '0);
`ifdef FN_DIVISION_CERO_RAPIDO_EN
                    if (b == '0) count_d = CW'(1);
`endif
                end
            end
            CALC: begin
                dvd_d   = dvd_next;
                rem_d   = rem_next;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    // Zero divisor overrides the sign fix: all-ones quotient, dividend as remainder.
                    cociente_d = cero_q ? '1 : (sgn_c_q ? -dvd_next : dvd_next);
                    resto_d    = cero_q ? a_orig_q : (sgn_r_q ? -rem_next : rem_next);
                end
            end
            default: state_d = IDLE;
        endcase

        ocupado_d = (state_d == CALC);
        listo_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            a_orig_q   <= '0;
            sgn_c_q    <= 1'b0;
            sgn_r_q    <= 1'b0;
            cero_q     <= 1'b0;
            cociente_q <= '0;
            resto_q    <= '0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            a_orig_q   <= a_orig_d;
            sgn_c_q    <= sgn_c_d;
            sgn_r_q    <= sgn_r_d;
            cero_q     <= cero_d;
            cociente_q <= cociente_d;
            resto_q    <= resto_d;
            ocupado_q  <= ocupado_d;
            listo_q    <= listo_d;
        end
    end

    assign ocupado    = ocupado_q;
    assign listo      = listo_q;
    assign div_cero   = listo_q & cero_q;
    assign cociente   = cociente_q;
    assign resto      = resto_q;
    assign estado_dbg = state_q;
endmodule

// File: tb/tb_fn_division.sv
// Directed bench for fn_division: hand-computed quotient/remainder, latency, handshake and reset checks.
module tb_fn_division;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         inicio;
    logic [W-1:0] a, b;
    logic         con_signo;
    logic         ocupado, listo, div_cero;
    logic [W-1:0] cociente, resto;
    logic [1:0]   estado_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W:0] exp_q[$];
    bit both_seen = 1'b0;

    fn_division #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .a(a), .b(b), .con_signo(con_signo),
        .ocupado(ocupado), .listo(listo), .div_cero(div_cero),
        .cociente(cociente), .resto(resto), .estado_dbg(estado_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ocupado && listo) both_seen = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        @(negedge clk);
        a = av; b = bv; con_signo = sv; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic wait_listo(output int cycles);
        cycles = 0;
        while (!listo && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic compare_result(input string tag);
        logic [2*W:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_cociente"}, cociente, e[2*W-1:W]);
        check({tag, "_resto"}, resto, e[W-1:0]);
        check({tag, "_div_cero"}, div_cero, e[2*W]);
        check({tag, "_listo"}, listo, 1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez);
        int cyc;
        int exp_lat;
        exp_q.push_back({ez, eq, er});
        start_op(av, bv, sv);
        check({tag, "_ocupado"}, ocupado, 1);
        wait_listo(cyc);
        exp_lat = W;
`ifdef FN_DIVISION_CERO_RAPIDO_EN
        if (bv == '0) exp_lat = 1;
`endif
        check({tag, "_latency"}, cyc, exp_lat);
        compare_result(tag);
    endtask

    initial begin
        int cyc;
        rst = 1'b1; inicio = 1'b0; a = '0; b = '0; con_signo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ocupado", ocupado, 0);
        check("rst_listo", listo, 0);
        check("rst_div_cero", div_cero, 0);
        check("rst_cociente", cociente, 0);
        check("rst_resto", resto, 0);
        check("rst_estado", estado_dbg, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("u_100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0);
        run_op("s_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run_op("s_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0);
        run_op("u_5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("s_5_0",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1);
        run_op("s_m5_0",    32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);
        run_op("s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0);
        run_op("u_max_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0);
        run_op("u_max_2",   32'hFFFF_FFFF,  32'd2,          1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0);
        run_op("s_min_2",   32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          1'b0);
        run_op("u_min_big", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0);

        // inicio held high mid-calculation with different operands must be ignored
        exp_q.push_back({1'b0, 32'd14, 32'd2});
        start_op(32'd100, 32'd7, 1'b0);
        @(negedge clk);
        a = 32'd9; b = 32'd3; inicio = 1'b1;
        repeat (4) @(negedge clk);
        inicio = 1'b0;
        wait_listo(cyc);
        check("hold_latency", cyc, W - 5);
        compare_result("hold");

        // back-to-back start from DONE: listo drops on the accept edge, old result still visible
        exp_q.push_back({1'b0, 32'd3, 32'd0});
        start_op(32'd9, 32'd3, 1'b0);
        check("b2b_listo_drop", listo, 0);
        check("b2b_ocupado", ocupado, 1);
        check("b2b_cociente_stable", cociente, 32'd14);
        wait_listo(cyc);
        check("b2b_latency", cyc, W);
        compare_result("b2b");

        // asynchronous reset in the middle of an operation
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ocupado", ocupado, 0);
        check("arst_listo", listo, 0);
        check("arst_cociente", cociente, 0);
        check("arst_resto", resto, 0);
        check("arst_estado", estado_dbg, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);

        check("never_both_high", both_seen, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
